// File: rtl/interp_quarter_seq.sv
// interp_quarter_seq
// Sequential quarter-position linear interpolator. It takes a pilot pair A/B
// and emits Q1, Q2 and Q3 (roughly 3/4A+1/4B, 1/2A+1/2B, 1/4A+3/4B) one at a
// time over a valid/ready output, using a single accumulate adder.
//
// Optional feature macro: INTERP_ROUND_EN
//   defined   -> round-half-up of the exact quarter value (RND = 2)
//   undefined -> floor, i.e. truncation toward minus infinity (RND = 0)
module interp_quarter_seq #(
  parameter int WIDTH = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [1:0]              out_idx,
  output logic                    out_last
);

`ifdef INTERP_ROUND_EN
  localparam logic [1:0] RND = 2'd2;
`else
  localparam logic [1:0] RND = 2'd0;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIFF = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]              state_reg, state_next;
  logic signed [WIDTH-1:0] a_reg, a_next;
  logic signed [WIDTH-1:0] b_reg, b_next;
  logic signed [WIDTH:0]   d_reg, d_next;
  logic signed [WIDTH+2:0] acc_reg, acc_next;
  logic [1:0]              idx_reg, idx_next;

  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH:0]   addend;
  logic signed [WIDTH+2:0] acc_sum;
  logic signed [WIDTH+2:0] acc_init;

  // Datapath: B-A at WIDTH+1 cannot overflow; the accumulate adder takes the
  // freshly computed difference in DIFF and the stored one in EMIT.
  always_comb begin
    diff     = {b_reg[WIDTH-1], b_reg} - {a_reg[WIDTH-1], a_reg};
    addend   = (state_reg == ST_DIFF) ? diff : d_reg;
    acc_sum  = acc_reg + {{2{addend[WIDTH]}}, addend};
    // 4*A by concatenation; the two zero LSBs leave room to place RND directly.
    acc_init = {in_a[WIDTH-1], in_a, RND};
  end

  // Next-state and register-update logic for the IDLE -> DIFF -> EMIT sequence.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    d_next     = d_reg;
    acc_next   = acc_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          a_next     = in_a;
          b_next     = in_b;
          acc_next   = acc_init;
          state_next = ST_DIFF;
        end
      end
      ST_DIFF: begin
        d_next     = diff;
        acc_next   = acc_sum;
        idx_next   = 2'd1;
        state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (idx_reg == 2'd3) begin
            state_next = ST_IDLE;
          end else begin
            acc_next = acc_sum;
            idx_next = idx_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over a concurrent pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      d_reg     <= '0;
      acc_reg   <= '0;
      idx_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      d_reg     <= d_next;
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
    end
  end

  // Outputs are gated by state so IDLE always presents zeros, not stale results.
  // acc[WIDTH+1:2] equals (acc >>> 2) truncated to WIDTH bits.
  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_EMIT);
    out_data  = out_valid ? acc_reg[WIDTH+1:2] : '0;
    out_idx   = out_valid ? idx_reg : 2'd0;
    out_last  = out_valid && (idx_reg == 2'd3);
  end

endmodule

// File: tb/tb_interp_quarter_seq.sv
// Testbench for interp_quarter_seq: scoreboard of expected quarter estimates,
// directed timing/backpressure/reset cases and a random backpressure phase.
module tb_interp_quarter_seq;
  localparam int WIDTH = 17;

`ifdef INTERP_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_a;
  logic signed [WIDTH-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic [1:0]              out_idx;
  logic                    out_last;

  typedef struct {
    int data;
    int idx;
    int last;
    int a;
    int b;
  } exp_t;

  exp_t sb[$];
  int   check_count = 0;
  int   error_count = 0;

  interp_quarter_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Exact quarter value k/4 of the way from A to B, floored after adding RND.
  function automatic int qval(input int a, input int b, input int k);
    int num;
    num = (4 - k) * a + k * b + RND;
    return num >>> 2;
  endfunction

  // Monitor: pop and compare each accepted output beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        $display("out a=%0d b=%0d idx=%0d data=%0d last=%0d", e.a, e.b,
                 out_idx, $signed(out_data), out_last);
        check("out_data", int'($signed(out_data)), e.data);
        check("out_idx", int'(out_idx), e.idx);
        check("out_last", int'(out_last), e.last);
      end
    end
  end

  // Entry and exit: 1 time unit after a rising edge. Returns in the cycle after acceptance.
  task automatic send_pair(input int a, input int b);
    int   n;
    exp_t e;
    in_a     = a[WIDTH-1:0];
    in_b     = b[WIDTH-1:0];
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    $display("in  a=%0d b=%0d", a, b);
    for (int k = 1; k <= 3; k++) begin
      e.data = qval(a, b, k);
      e.idx  = k;
      e.last = (k == 3) ? 1 : 0;
      e.a    = a;
      e.b    = b;
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Pair with out_ready high: Q1..Q3 at T+2..T+4, IDLE again at T+5.
  task automatic run_timed(input int a, input int b);
    send_pair(a, b);
    check("diff_out_valid", int'(out_valid), 0);
    check("diff_in_ready", int'(in_ready), 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("q_valid", int'(out_valid), 1);
      check("q_idx", int'(out_idx), k);
      check("q_last", int'(out_last), (k == 3) ? 1 : 0);
      check("q_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    check("reidle_in_ready", int'(in_ready), 1);
    check("reidle_out_valid", int'(out_valid), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int ra_i;
    int rb_i;
    logic signed [WIDTH-1:0] rv;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'($signed(out_data)), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed pairs with exact latency checks.
    run_timed(100, 200);
    run_timed(0, 3);
    run_timed(-4, -8);
    run_timed(-65536, 65535);
    run_timed(65535, -65536);

    // Backpressure at Q2 with ignored input pulses.
    out_ready = 1'b1;
    send_pair(10, 50);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'($signed(out_data)), qval(10, 50, 2));
      check("stall_idx", int'(out_idx), 2);
      check("stall_in_ready", int'(in_ready), 0);
      in_valid = 1'b1;
      in_a     = 17'sd7;
      in_b     = 17'sd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_stall_idx", int'(out_idx), 3);
    check("post_stall_data", int'($signed(out_data)), qval(10, 50, 3));
    @(posedge clk); #1;
    check("post_stall_idle", int'(in_ready), 1);
    drain();

    // Reset while Q1 is presented discards the sequence.
    send_pair(100, 200);
    @(posedge clk); #1;
    check("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_data", int'($signed(out_data)), 0);
    check("mid_rst_out_last", int'(out_last), 0);
    run_timed(8, 0);

    // Reset and in_valid together: the pair must not be accepted.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 17'sd5;
    in_b     = 17'sd9;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("rst_vs_valid_ready", int'(in_ready), 1);
      check("rst_vs_valid_out", int'(out_valid), 0);
      @(posedge clk); #1;
    end

    // Random pairs under random backpressure.
    fork
      begin
        for (int p = 0; p < 12; p++) begin
          rv   = WIDTH'($urandom);
          ra_i = rv;
          rv   = WIDTH'($urandom);
          rb_i = rv;
          send_pair(ra_i, rb_i);
        end
      end
      begin
        for (int c = 0; c < 200; c++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
